// File: rtl/add_seq_ctrl_amisha.sv
// rtl/add_seq_ctrl_amisha.sv - chunk-serial adder/subtractor, one N-bit chunk per cycle
// Operands are latched on start; busy covers ADD and DONE, done pulses once per result.
module add_seq_ctrl_amisha #(
   parameter int N = 4,
   parameter int W = 4
) (
   input  logic           clk_amisha,
   input  logic           rst_n_amisha,
   input  logic           start_amisha,
   input  logic           sub_amisha,
   input  logic           cin_amisha,
   input  logic [N*W-1:0] a_amisha,
   input  logic [N*W-1:0] b_amisha,
   output logic           busy_amisha,
   output logic           done_amisha,
   output logic [N*W-1:0] sum_amisha,
   output logic           cout_amisha
);
   localparam int IW = $clog2(W);
   localparam logic [IW-1:0] LAST = IW'(W - 1);

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t         state;
   state_t         state_nx;
   logic [N*W-1:0] a_q;
   logic [N*W-1:0] b_q;
   logic           sub_q;
   logic           carry_q;
   logic [IW-1:0]  idx_q;
   logic [N-1:0]   a_chunk;
   logic [N-1:0]   b_chunk;
   logic [N:0]     chunk_sum;
   logic           last_chunk;

   // Subtraction is A + ~B + 1: the +1 comes from the carry preloaded at start.
   assign a_chunk    = a_q[int'(idx_q)*N +: N];
   assign b_chunk    = b_q[int'(idx_q)*N +: N] ^ {N{sub_q}};
   assign chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{N{1'b0}}, carry_q};
   assign last_chunk = (idx_q == LAST);

   always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
      if (!rst_n_amisha) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      busy_amisha = 1'b0;
      done_amisha = 1'b0;
      case (state)
         IDLE: begin
            if (start_amisha) begin
               state_nx = ADD;
            end
         end
         ADD: begin
            busy_amisha = 1'b1;
            if (last_chunk) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            busy_amisha = 1'b1;
            done_amisha = 1'b1;
            state_nx    = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
      if (!rst_n_amisha) begin
         a_q         <= '0;
         b_q         <= '0;
         sub_q       <= 1'b0;
         carry_q     <= 1'b0;
         idx_q       <= '0;
         sum_amisha  <= '0;
         cout_amisha <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_amisha) begin
                  a_q     <= a_amisha;
                  b_q     <= b_amisha;
                  sub_q   <= sub_amisha;
                  carry_q <= sub_amisha ? 1'b1 : cin_amisha;
                  idx_q   <= '0;
               end
            end
            ADD: begin
               sum_amisha[int'(idx_q)*N +: N] <= chunk_sum[N-1:0];
               carry_q <= chunk_sum[N];
               if (last_chunk) begin
                  cout_amisha <= chunk_sum[N];
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end
endmodule

// File: doc/add_seq_ctrl_amisha.md
ADD_SEQ_CTRL_AMISHA -- requirements
Module: add_seq_ctrl_amisha

Interface
REQ-001 The block SHALL have parameter N, default 4: chunk width in bits, the width of the add performed per cycle.
REQ-002 The block SHALL have parameter W, default 4 (range 2..16): number of chunks; operand width is N*W.
REQ-003 clk_amisha  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n_amisha  input  1  reset, asynchronous and active-low.
REQ-005 start_amisha  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 sub_amisha  input  1  0 = add, 1 = subtract (a - b); sampled with start.
REQ-007 cin_amisha  input  1  carry-in for add mode; ignored in subtract mode.
REQ-008 a_amisha  input  N*W  operand A; sampled with start.
REQ-009 b_amisha  input  N*W  operand B; sampled with start.
REQ-010 busy_amisha  output  1  high while an operation is in progress.
REQ-011 done_amisha  output  1  single-cycle pulse marking result valid.
REQ-012 sum_amisha  output  N*W  result; held stable from done until the next accepted start.
REQ-013 cout_amisha  output  1  final carry-out (subtract: 1 = no borrow).

Function
REQ-014 FSM states SHALL be IDLE, ADD and DONE.
REQ-015 In IDLE with start_amisha=1, the block SHALL latch a, b and sub, clear the chunk index to 0, and load the carry register with cin_amisha (add) or 1 (subtract); next state ADD.
REQ-016 In IDLE with start_amisha=0, the FSM SHALL remain in IDLE and all registers SHALL hold.
REQ-017 In ADD, each cycle k (k = 0..W-1) SHALL compute chunk k as {1'b0,a_k} + {1'b0,b'_k} + carry in N+1 bits, where b'_k is b_k (add) or ~b_k (subtract).
REQ-018 Result bits [N-1:0] of that sum SHALL be written to sum bits [k*N +: N]; bit N SHALL become the next carry.
REQ-019 When k = W-1, the FSM SHALL move to DONE and cout_amisha SHALL take the final carry; otherwise k increments.
REQ-020 In DONE, done_amisha SHALL be 1 for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-021 busy_amisha SHALL be 1 in ADD and DONE and 0 in IDLE.
REQ-022 Latency from the start-accept edge to done_amisha high SHALL be W+1 cycles; back-to-back starts SHALL yield one result every W+2 cycles.
REQ-023 start_amisha asserted while busy SHALL be ignored and SHALL NOT be queued.
REQ-024 Changes on a, b, sub or cin after acceptance SHALL NOT affect the operation in progress.
REQ-025 sum_amisha bits of chunks not yet processed SHALL retain their previous values during ADD (partial updates are permitted to be visible).
REQ-026 The result SHALL equal (A + B + cin) mod 2^(N*W) with cout = bit N*W (add), and (A - B) mod 2^(N*W) with cout = (A >= B) (subtract).

Reset
REQ-027 On rst_n_amisha=0, the block SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, carry=0 and chunk index=0, regardless of clock.
REQ-028 Reset asserted mid-operation SHALL abort it; no done pulse SHALL follow reset release.
REQ-029 After reset release, the first rising edge with start=1 SHALL be accepted.

Verification (N=4, W=4)
REQ-030 Add: A=0x1234, B=0x0FFF, cin=0 -> done in cycle 5 after accept, sum=0x2233, cout=0.
REQ-031 Full carry ripple: A=0xFFFF, B=0x0000, cin=1 -> sum=0x0000, cout=1; busy high for 5 cycles.
REQ-032 Subtract: A=0x0005, B=0x0007, sub=1 -> sum=0xFFFE, cout=0; A=0x0007, B=0x0005 -> sum=0x0002, cout=1.
REQ-033 start held high continuously for 20 cycles -> exactly 3 done pulses, spaced 6 cycles apart, each result correct; operands changed mid-operation do not alter the result.
REQ-034 Reset pulsed during ADD at k=2 -> outputs immediately 0; no done pulse; a following start with A=0x0001, B=0x0001 gives sum=0x0002.
REQ-035 Random regression of 1000 operations, both modes, random cin, compared against a reference model per REQ-026.
